l2_arbiter: RTL

L2_ARBITER -- requirements
Module: L2_ARBITER

---
 rtl/l2_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/l2_arbiter.sv
// Shares one L2 read port between the instruction and data caches.
// One transaction in flight; ties alternate away from the last grant.
module l2_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int L2_BUS_WIDTH  = 32
) (
    input  logic                     CLK,
    input  logic                     RST,

    input  logic                     ADDRESS_TO_L2_VALID_INS,
    input  logic [ADDRESS_WIDTH-3:0] ADDRESS_TO_L2_INS,
    output logic                     ADDRESS_TO_L2_READY_INS,
    output logic                     DATA_FROM_L2_VALID_INS,
    output logic [L2_BUS_WIDTH-1:0]  DATA_FROM_L2_INS,
    input  logic                     DATA_FROM_L2_READY_INS,

    input  logic                     ADDRESS_TO_L2_VALID_DAT,
    input  logic [ADDRESS_WIDTH-3:0] ADDRESS_TO_L2_DAT,
    output logic                     ADDRESS_TO_L2_READY_DAT,
    output logic                     DATA_FROM_L2_VALID_DAT,
    output logic [L2_BUS_WIDTH-1:0]  DATA_FROM_L2_DAT,
    input  logic                     DATA_FROM_L2_READY_DAT,

    output logic                     ADDRESS_TO_L2_VALID,
    output logic [ADDRESS_WIDTH-3:0] ADDRESS_TO_L2,
    input  logic                     ADDRESS_TO_L2_READY,
    input  logic                     DATA_FROM_L2_VALID,
    input  logic [L2_BUS_WIDTH-1:0]  DATA_FROM_L2,
    output logic                     DATA_FROM_L2_READY
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    localparam logic SEL_INS = 1'b0;
    localparam logic SEL_DAT = 1'b1;

    logic [1:0]               state;
    logic [1:0]               state_nxt;
    logic                     owner;
    logic                     last_gnt;
    logic [ADDRESS_WIDTH-3:0] addr_q;

    logic in_idle;
    logic in_addr;
    logic in_data;
    logic win_ins;
    logic win_dat;
    logic gnt_ins;
    logic gnt_dat;
    logic own_rdy;
    logic l2_data_hs;

    // Outputs are forced quiet while reset is held, even before
    // the first reset edge has cleaned up the state register.
    assign in_idle = (state == IDLE) && !RST;
    assign in_addr = (state == ADDR) && !RST;
    assign in_data = (state == DATA) && !RST;

    // Pick the idle winner; a tie goes to the side not granted last.
    always_comb begin
        win_ins = 1'b0;
        win_dat = 1'b0;
        unique case (1'b1)
            (ADDRESS_TO_L2_VALID_INS && !ADDRESS_TO_L2_VALID_DAT): begin
                win_ins = 1'b1;
            end
            (!ADDRESS_TO_L2_VALID_INS && ADDRESS_TO_L2_VALID_DAT): begin
                win_dat = 1'b1;
            end
            (ADDRESS_TO_L2_VALID_INS && ADDRESS_TO_L2_VALID_DAT): begin
                win_ins = (last_gnt == SEL_DAT);
                win_dat = (last_gnt == SEL_INS);
            end
            default: begin
                win_ins = 1'b0;
                win_dat = 1'b0;
            end
        endcase
    end

    assign ADDRESS_TO_L2_READY_INS = in_idle && win_ins;
    assign ADDRESS_TO_L2_READY_DAT = in_idle && win_dat;

    assign gnt_ins = ADDRESS_TO_L2_READY_INS && ADDRESS_TO_L2_VALID_INS;
    assign gnt_dat = ADDRESS_TO_L2_READY_DAT && ADDRESS_TO_L2_VALID_DAT;

    assign ADDRESS_TO_L2_VALID = in_addr;
    assign ADDRESS_TO_L2       = RST ? '0 : addr_q;

    assign own_rdy = (owner == SEL_DAT) ? DATA_FROM_L2_READY_DAT
                                        : DATA_FROM_L2_READY_INS;

    assign DATA_FROM_L2_READY = in_data && own_rdy;

    assign DATA_FROM_L2_VALID_INS = in_data && (owner == SEL_INS)
                                    && DATA_FROM_L2_VALID;
    assign DATA_FROM_L2_VALID_DAT = in_data && (owner == SEL_DAT)
                                    && DATA_FROM_L2_VALID;

    // Read data fans out to both caches; only the VALIDs steer it.
    assign DATA_FROM_L2_INS = DATA_FROM_L2;
    assign DATA_FROM_L2_DAT = DATA_FROM_L2;

    assign l2_data_hs = DATA_FROM_L2_VALID && DATA_FROM_L2_READY;

    // Transaction sequencing: grant, L2 address, L2 data.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (gnt_ins || gnt_dat) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (ADDRESS_TO_L2_READY) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (l2_data_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, captured address and grant bookkeeping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            addr_q   <= '0;
            owner    <= SEL_INS;
            last_gnt <= SEL_DAT;
        end else begin
            state <= state_nxt;
            if (gnt_ins || gnt_dat) begin
                addr_q   <= gnt_dat ? ADDRESS_TO_L2_DAT
                                    : ADDRESS_TO_L2_INS;
                owner    <= gnt_dat;
                last_gnt <= gnt_dat;
            end
        end
    end

endmodule
